// File: rtl/viterbi_fifo.sv
// Single-lane entry buffer for the Viterbi threader: stores {start_loc, din} windows
// and presents the oldest entry first-word-fall-through to the decoder lane.
module viterbi_fifo #(
  parameter int depth         = 4,
  parameter int num_of_chunks = 5,
  parameter int data_width    = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             push_n,
  input  logic                             clr,
  input  logic                             init_n,
  input  logic [$clog2(num_of_chunks)-1:0] start_loc,
  input  logic [data_width-1:0]            din,
  input  logic                             pop,
  output logic                             valid,
  output logic [data_width-1:0]            dout,
  output logic [$clog2(num_of_chunks)-1:0] dout_loc,
  output logic                             full,
  output logic [$clog2(depth+1)-1:0]       count,
  output logic                             armed,
  output logic                             overflow,
  output logic                             underflow
);

  localparam int LW = $clog2(num_of_chunks);
  localparam int PW = $clog2(depth);
  localparam int CW = $clog2(depth + 1);

  typedef struct packed {
    logic [LW-1:0]         loc;
    logic [data_width-1:0] data;
  } entry_t;

  entry_t          r_mem [depth];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_armed;
  logic            r_overflow;
  logic            r_underflow;

  logic            w_empty;
  logic            w_full;
  logic            w_clear;
  logic            w_push_req;
  logic            w_push_acc;
  logic            w_pop_acc;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CW'(depth));
  assign w_clear    = clr | ~init_n;
  assign w_pop_acc  = ~w_clear & pop & ~w_empty;
  assign w_push_req = ~push_n & r_armed;
  // A push into a full FIFO is legal when the head leaves on the same edge:
  // wr_ptr == rd_ptr then, so the new entry lands in the slot just vacated.
  assign w_push_acc = ~w_clear & w_push_req & (~w_full | w_pop_acc);

  // NOTE: storage is reset too, so dout/dout_loc read 0 out of reset instead of X.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < depth; i++) r_mem[i] <= '0;
    end else if (w_push_acc) begin
      r_mem[r_wr_ptr] <= '{loc: start_loc, data: din};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees
  // pre-edge values, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_armed     <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (!init_n) r_armed <= 1'b1;
      if (w_clear) begin
        r_wr_ptr    <= '0;
        r_rd_ptr    <= '0;
        r_count     <= '0;
        r_overflow  <= 1'b0;
        r_underflow <= 1'b0;
      end else begin
        if (w_push_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop_acc)  r_rd_ptr <= r_rd_ptr + 1'b1;
        case ({w_push_acc, w_pop_acc})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
        if (w_push_req && !w_push_acc) r_overflow  <= 1'b1;
        if (pop && w_empty)            r_underflow <= 1'b1;
      end
    end
  end

  assign valid     = ~w_empty;
  assign dout      = r_mem[r_rd_ptr].data;
  assign dout_loc  = r_mem[r_rd_ptr].loc;
  assign full      = w_full;
  assign count     = r_count;
  assign armed     = r_armed;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule

// File: tb/tb_viterbi_fifo.sv
// Self-checking bench for viterbi_fifo: directed scenarios plus randomized traffic
// compared every cycle against a queue-based reference model.
module tb_viterbi_fifo;

  localparam int DEPTH = 4;
  localparam int LW    = 3;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          push_n = 1'b1;
  logic          clr = 1'b0;
  logic          init_n = 1'b1;
  logic [LW-1:0] start_loc = '0;
  logic [DW-1:0] din = '0;
  logic          pop = 1'b0;
  logic          valid;
  logic [DW-1:0] dout;
  logic [LW-1:0] dout_loc;
  logic          full;
  logic [2:0]    count;
  logic          armed;
  logic          overflow;
  logic          underflow;

  int n_tests = 0;
  int n_fail  = 0;

  viterbi_fifo #(.depth(DEPTH), .num_of_chunks(5), .data_width(DW)) dut (
    .clk(clk), .rst(rst), .push_n(push_n), .clr(clr), .init_n(init_n),
    .start_loc(start_loc), .din(din), .pop(pop), .valid(valid), .dout(dout),
    .dout_loc(dout_loc), .full(full), .count(count), .armed(armed),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of {loc, data} plus three flags.
  logic [LW+DW-1:0] m_q[$];
  bit               m_armed = 0;
  bit               m_ovf   = 0;
  bit               m_udf   = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_armed = 0;
      m_ovf   = 0;
      m_udf   = 0;
    end else if (clr || !init_n) begin
      m_q.delete();
      m_ovf = 0;
      m_udf = 0;
      if (!init_n) m_armed = 1;
    end else begin
      bit pop_ok, push_req, push_ok;
      pop_ok   = pop && (m_q.size() > 0);
      push_req = !push_n && m_armed;
      push_ok  = push_req && ((m_q.size() < DEPTH) || pop_ok);
      if (pop && m_q.size() == 0) m_udf = 1;
      if (push_req && !push_ok)   m_ovf = 1;
      if (pop_ok)  void'(m_q.pop_front());
      if (push_ok) m_q.push_back({start_loc, din});
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("valid",     valid,     m_q.size() != 0);
      check("count",     count,     m_q.size());
      check("full",      full,      m_q.size() == DEPTH);
      check("armed",     armed,     m_armed);
      check("overflow",  overflow,  m_ovf);
      check("underflow", underflow, m_udf);
      if (m_q.size() != 0) begin
        check("dout",     dout,     m_q[0][DW-1:0]);
        check("dout_loc", dout_loc, m_q[0][LW+DW-1:DW]);
      end
    end
  end

  task automatic cyc(input logic pn, input logic p, input logic c, input logic in_n,
                     input logic [DW-1:0] d, input logic [LW-1:0] l);
    push_n = pn; pop = p; clr = c; init_n = in_n; din = d; start_loc = l;
    @(posedge clk);
    @(negedge clk);
    push_n = 1'b1; pop = 1'b0; clr = 1'b0; init_n = 1'b1;
  endtask

  task automatic expect_head(input logic [DW-1:0] d, input logic [LW-1:0] l);
    check("head_valid", valid, 1'b1);
    check("head_dout", dout, d);
    check("head_loc", dout_loc, l);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_count", count, 0);
    check("rst_valid", valid, 0);
    check("rst_armed", armed, 0);
    check("rst_dout", dout, 0);
    check("rst_loc", dout_loc, 0);
    rst = 1'b0;
    @(negedge clk);

    // Arm gating: pushes before init_n are ignored, not overflow.
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h11, 3'd1);
    check("gate_count", count, 0);
    check("gate_ovf", overflow, 0);
    check("gate_armed", armed, 0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 3'd0);
    check("init_armed", armed, 1);

    // Fill and overflow.
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'hA0 + i, LW'(i));
      if (i == 3) begin
        check("fill_count", count, 4);
        check("fill_full", full, 1);
        check("fill_ovf0", overflow, 0);
      end
    end
    check("ovf_set", overflow, 1);
    check("ovf_count", count, 4);
    expect_head(32'hA0, 3'd0);

    // Push and pop together while full.
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 32'hB0, 3'd4);
    check("both_count", count, 4);
    check("both_ovf", overflow, 1);
    expect_head(32'hA1, 3'd1);
    for (int i = 1; i < 4; i++) begin
      expect_head(32'hA0 + i, LW'(i));
      cyc(1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 3'd0);
    end
    expect_head(32'hB0, 3'd4);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 3'd0);
    check("drain_valid", valid, 0);
    check("drain_count", count, 0);

    // Push with pop on empty: no bypass, underflow set.
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 32'hC0, 3'd2);
    check("empty_udf", underflow, 1);
    check("empty_count", count, 1);
    expect_head(32'hC0, 3'd2);

    // Clear beats push and pop.
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'hD0, 3'd3);
    check("pre_clr_count", count, 2);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 32'hE0, 3'd1);
    check("clr_count", count, 0);
    check("clr_valid", valid, 0);
    check("clr_ovf", overflow, 0);
    check("clr_udf", underflow, 0);
    check("clr_armed", armed, 1);

    // Randomized traffic, including wrap-around and occasional clears.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 99) < 60) ? 1'b0 : 1'b1,
          ($urandom_range(0, 99) < 45) ? 1'b1 : 1'b0,
          ($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0,
          ($urandom_range(0, 79) == 0) ? 1'b0 : 1'b1,
          $urandom, LW'($urandom_range(0, 4)));
    end

    // Asynchronous reset mid-cycle takes effect without a clock edge.
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'hF0, 3'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_count", count, 0);
    check("arst_valid", valid, 0);
    check("arst_armed", armed, 0);
    check("arst_full", full, 0);
    check("arst_dout", dout, 0);
    check("arst_ovf", overflow, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
